// File: rtl/uvma_rvfi_retire_serializer.sv
// Multi-retire RVFI front end: compacts up to NRET retirements per cycle into a
// circular FIFO and replays them one per cycle on a ready/valid stream.
// Sticky status flags record dropped retire groups and order-number gaps.
module uvma_rvfi_retire_serializer #(
  parameter  int NRET        = 2,
  parameter  int DEPTH       = 8,
  parameter  int ILEN        = 32,
  parameter  int XLEN        = 32,
  parameter  int ORDER_WL    = 64,
  parameter  int GPR_ADDR_WL = 5,
  localparam int CNT_W       = $clog2(DEPTH + 1)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NRET-1:0]               rvfi_valid,
  input  logic [NRET*ORDER_WL-1:0]      rvfi_order,
  input  logic [NRET*ILEN-1:0]          rvfi_insn,
  input  logic [NRET-1:0]               rvfi_trap,
  input  logic [NRET*XLEN-1:0]          rvfi_pc_rdata,
  input  logic [NRET*GPR_ADDR_WL-1:0]   rvfi_rd1_addr,
  input  logic [NRET*XLEN-1:0]          rvfi_rd1_wdata,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [ORDER_WL-1:0]           out_order,
  output logic [ILEN-1:0]               out_insn,
  output logic                          out_trap,
  output logic [XLEN-1:0]               out_pc_rdata,
  output logic [GPR_ADDR_WL-1:0]        out_rd1_addr,
  output logic [XLEN-1:0]               out_rd1_wdata,
  output logic [CNT_W-1:0]              count,
  output logic                          overflow,
  output logic                          order_err
);

  // DEPTH must be a power of two so that pointer wrap is plain overflow.
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef struct packed {
    logic [ORDER_WL-1:0]    order;
    logic [ILEN-1:0]        insn;
    logic                   trap;
    logic [XLEN-1:0]        pc_rdata;
    logic [GPR_ADDR_WL-1:0] rd1_addr;
    logic [XLEN-1:0]        rd1_wdata;
  } entry_t;

  entry_t                mem_q [DEPTH];
  entry_t                mem_d [DEPTH];
  entry_t                head_q, head_d;
  entry_t                lane;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]      slot;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  overflow_q, overflow_d;
  logic                  order_err_q, order_err_d;
  logic                  expect_vld_q, expect_vld_d;
  logic [ORDER_WL-1:0]   expect_q, expect_d;
  logic [CNT_W:0]        n_lanes;
  logic [CNT_W:0]        free_slots;
  logic                  accept;
  logic                  pop;

  assign out_valid = (count_q != '0);
  assign pop       = out_valid && out_ready;

  // Count valid lanes and decide whether the whole group fits; a same-cycle
  // pop frees one slot, and groups are never split.
  always_comb begin
    n_lanes = '0;
    for (int i = 0; i < NRET; i++) begin
      if (rvfi_valid[i]) n_lanes = n_lanes + (CNT_W+1)'(1);
    end
    free_slots = (CNT_W+1)'(DEPTH) - {1'b0, count_q} + (CNT_W+1)'(pop);
    accept     = (n_lanes <= free_slots);
  end

  // Compact valid lanes into the FIFO, walk the order check over them in the
  // same order, and precompute the head entry that the outputs register.
  always_comb begin
    mem_d        = mem_q;
    expect_d     = expect_q;
    expect_vld_d = expect_vld_q;
    order_err_d  = order_err_q;
    overflow_d   = overflow_q | ~accept;
    slot         = '0;
    lane         = '0;
    for (int i = 0; i < NRET; i++) begin
      lane.order     = rvfi_order[i*ORDER_WL +: ORDER_WL];
      lane.insn      = rvfi_insn[i*ILEN +: ILEN];
      lane.trap      = rvfi_trap[i];
      lane.pc_rdata  = rvfi_pc_rdata[i*XLEN +: XLEN];
      lane.rd1_addr  = rvfi_rd1_addr[i*GPR_ADDR_WL +: GPR_ADDR_WL];
      lane.rd1_wdata = rvfi_rd1_wdata[i*XLEN +: XLEN];
      if (accept && rvfi_valid[i]) begin
        mem_d[wr_ptr_q + slot] = lane;
        // Resync on every entry so one gap is reported once, not per entry.
        if (expect_vld_d && (lane.order != expect_d)) order_err_d = 1'b1;
        expect_d     = lane.order + ORDER_WL'(1);
        expect_vld_d = 1'b1;
        slot         = slot + PTR_W'(1);
      end
    end
    // When n == DEPTH the slot counter wraps to zero, which is the correct
    // modulo-DEPTH advance.
    wr_ptr_d = wr_ptr_q + slot;
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    count_d  = count_q + (accept ? n_lanes[CNT_W-1:0] : '0) - CNT_W'(pop);
    // Outputs hold their last value once the FIFO runs empty.
    head_d   = head_q;
    if (count_d != '0) head_d = mem_d[rd_ptr_d];
  end

  // State registers; everything clears immediately on reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      head_q       <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      overflow_q   <= 1'b0;
      order_err_q  <= 1'b0;
      expect_vld_q <= 1'b0;
      expect_q     <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
      head_q       <= head_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      overflow_q   <= overflow_d;
      order_err_q  <= order_err_d;
      expect_vld_q <= expect_vld_d;
      expect_q     <= expect_d;
    end
  end

  assign out_order     = head_q.order;
  assign out_insn      = head_q.insn;
  assign out_trap      = head_q.trap;
  assign out_pc_rdata  = head_q.pc_rdata;
  assign out_rd1_addr  = head_q.rd1_addr;
  assign out_rd1_wdata = head_q.rd1_wdata;
  assign count         = count_q;
  assign overflow      = overflow_q;
  assign order_err     = order_err_q;

endmodule

// File: tb/tb_uvma_rvfi_retire_serializer.sv
// Directed bench for the RVFI retire serializer (NRET=2, DEPTH=8).
module tb_uvma_rvfi_retire_serializer;

  localparam int NRET = 2;
  localparam int DEPTH = 8;
  localparam int ILEN = 32;
  localparam int XLEN = 32;
  localparam int OWL = 64;
  localparam int AWL = 5;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic [NRET-1:0]     rvfi_valid = '0;
  logic [NRET*OWL-1:0] rvfi_order = '0;
  logic [NRET*ILEN-1:0] rvfi_insn = '0;
  logic [NRET-1:0]     rvfi_trap = '0;
  logic [NRET*XLEN-1:0] rvfi_pc_rdata = '0;
  logic [NRET*AWL-1:0] rvfi_rd1_addr = '0;
  logic [NRET*XLEN-1:0] rvfi_rd1_wdata = '0;
  logic                out_valid;
  logic                out_ready = 1'b0;
  logic [OWL-1:0]      out_order;
  logic [ILEN-1:0]     out_insn;
  logic                out_trap;
  logic [XLEN-1:0]     out_pc_rdata;
  logic [AWL-1:0]      out_rd1_addr;
  logic [XLEN-1:0]     out_rd1_wdata;
  logic [CNT_W-1:0]    count;
  logic                overflow;
  logic                order_err;

  int checks = 0;
  int errors = 0;

  uvma_rvfi_retire_serializer #(
    .NRET(NRET), .DEPTH(DEPTH), .ILEN(ILEN), .XLEN(XLEN),
    .ORDER_WL(OWL), .GPR_ADDR_WL(AWL)
  ) dut (
    .clk(clk), .reset(reset),
    .rvfi_valid(rvfi_valid), .rvfi_order(rvfi_order), .rvfi_insn(rvfi_insn),
    .rvfi_trap(rvfi_trap), .rvfi_pc_rdata(rvfi_pc_rdata),
    .rvfi_rd1_addr(rvfi_rd1_addr), .rvfi_rd1_wdata(rvfi_rd1_wdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_order(out_order),
    .out_insn(out_insn), .out_trap(out_trap), .out_pc_rdata(out_pc_rdata),
    .out_rd1_addr(out_rd1_addr), .out_rd1_wdata(out_rd1_wdata),
    .count(count), .overflow(overflow), .order_err(order_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Load one lane with an order number and payload derived from it.
  task automatic set_lane(input int i, input logic [63:0] ord);
    rvfi_valid[i]               = 1'b1;
    rvfi_order[i*OWL +: OWL]    = ord;
    rvfi_insn[i*ILEN +: ILEN]   = 32'h0000_1000 + ord[31:0];
    rvfi_trap[i]                = ord[0];
    rvfi_pc_rdata[i*XLEN +: XLEN] = {ord[29:0], 2'b00};
    rvfi_rd1_addr[i*AWL +: AWL] = ord[4:0];
    rvfi_rd1_wdata[i*XLEN +: XLEN] = ~ord[31:0];
  endtask

  task automatic idle();
    rvfi_valid = '0;
    rvfi_order = '0;
    rvfi_insn = '0;
    rvfi_trap = '0;
    rvfi_pc_rdata = '0;
    rvfi_rd1_addr = '0;
    rvfi_rd1_wdata = '0;
  endtask

  task automatic grp2(input logic [63:0] o0, input logic [63:0] o1);
    idle();
    set_lane(0, o0);
    set_lane(1, o1);
  endtask

  task automatic do_reset();
    idle();
    out_ready = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    // Reset state
    do_reset();
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);
    chk("rst_order_err", 64'(order_err), 64'd0);
    chk("rst_out_order", out_order, 64'd0);
    chk("rst_out_insn", 64'(out_insn), 64'd0);

    // Two lanes, streaming
    out_ready = 1'b1;
    grp2(64'd1, 64'd2);
    tick();
    idle();
    chk("basic_c1_valid", 64'(out_valid), 64'd1);
    chk("basic_c1_order", out_order, 64'd1);
    chk("basic_c1_count", 64'(count), 64'd2);
    chk("basic_c1_insn", 64'(out_insn), 64'h1001);
    chk("basic_c1_wdata", 64'(out_rd1_wdata), 64'hFFFF_FFFE);
    tick();
    chk("basic_c2_order", out_order, 64'd2);
    chk("basic_c2_pc", 64'(out_pc_rdata), 64'd8);
    chk("basic_c2_trap", 64'(out_trap), 64'd0);
    chk("basic_c2_rd", 64'(out_rd1_addr), 64'd2);
    tick();
    chk("basic_c3_valid", 64'(out_valid), 64'd0);
    chk("basic_c3_hold", out_order, 64'd2);
    chk("basic_order_err", 64'(order_err), 64'd0);

    // Sparse lane: only lane 1 valid, lane 0 carries junk
    do_reset();
    out_ready = 1'b0;
    idle();
    set_lane(0, 64'd77);
    rvfi_valid[0] = 1'b0;
    set_lane(1, 64'd5);
    rvfi_insn[ILEN +: ILEN] = 32'h0000_0013;
    tick();
    idle();
    chk("sparse_order", out_order, 64'd5);
    chk("sparse_insn", 64'(out_insn), 64'h13);
    chk("sparse_count", 64'(count), 64'd1);
    chk("sparse_trap", 64'(out_trap), 64'd1);

    // Fill to full, overflow, drain, then stale-expect order error
    do_reset();
    out_ready = 1'b0;
    for (int g = 0; g < 4; g++) begin
      grp2(64'(2*g+1), 64'(2*g+2));
      tick();
      chk("fill_count", 64'(count), 64'(2*g+2));
    end
    chk("fill_head", out_order, 64'd1);
    grp2(64'd9, 64'd10);
    tick();
    idle();
    chk("ovf_flag", 64'(overflow), 64'd1);
    chk("ovf_count", 64'(count), 64'd8);
    chk("ovf_head", out_order, 64'd1);
    chk("ovf_order_err", 64'(order_err), 64'd0);
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      chk("drain_valid", 64'(out_valid), 64'd1);
      chk("drain_order", out_order, 64'(i));
      tick();
    end
    chk("drain_empty", 64'(out_valid), 64'd0);
    grp2(64'd11, 64'd12);
    tick();
    idle();
    chk("stale_order_err", 64'(order_err), 64'd1);
    chk("stale_head", out_order, 64'd11);
    chk("stale_overflow_sticky", 64'(overflow), 64'd1);

    // Single gap flags once and stays set
    do_reset();
    out_ready = 1'b1;
    grp2(64'd1, 64'd2);
    tick();
    chk("gap_pre", 64'(order_err), 64'd0);
    idle();
    set_lane(0, 64'd4);
    tick();
    chk("gap_flag", 64'(order_err), 64'd1);
    idle();
    set_lane(1, 64'd5);
    tick();
    idle();
    chk("gap_sticky", 64'(order_err), 64'd1);

    // Push and pop together at full
    do_reset();
    out_ready = 1'b0;
    for (int g = 0; g < 4; g++) begin
      grp2(64'(2*g+1), 64'(2*g+2));
      tick();
    end
    idle();
    chk("full_count", 64'(count), 64'd8);
    out_ready = 1'b1;
    set_lane(0, 64'd9);
    tick();
    chk("full_pp_overflow", 64'(overflow), 64'd0);
    chk("full_pp_count", 64'(count), 64'd8);
    chk("full_pp_head", out_order, 64'd2);
    grp2(64'd10, 64'd11);
    tick();
    idle();
    chk("full_drop_overflow", 64'(overflow), 64'd1);
    chk("full_drop_count", 64'(count), 64'd7);
    chk("full_drop_head", out_order, 64'd3);

    // Order wrap from all-ones to zero is contiguous
    do_reset();
    out_ready = 1'b1;
    grp2(64'hFFFF_FFFF_FFFF_FFFF, 64'd0);
    tick();
    idle();
    set_lane(0, 64'd1);
    tick();
    idle();
    chk("wrap_order_err", 64'(order_err), 64'd0);
    chk("wrap_head", out_order, 64'd0);

    // Asynchronous reset mid-run
    do_reset();
    out_ready = 1'b0;
    for (int g = 0; g < 5; g++) begin
      grp2(64'(2*g+1), 64'(2*g+2));
      tick();
    end
    idle();
    out_ready = 1'b1;
    repeat (3) tick();
    out_ready = 1'b0;
    chk("mid_pre_count", 64'(count), 64'd5);
    chk("mid_pre_overflow", 64'(overflow), 64'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_count", 64'(count), 64'd0);
    chk("mid_rst_overflow", 64'(overflow), 64'd0);
    grp2(64'd50, 64'd51);
    tick();
    chk("mid_rst_ignore_push", 64'(count), 64'd0);
    reset = 1'b0;
    idle();
    set_lane(0, 64'd100);
    tick();
    idle();
    chk("mid_after_order_err", 64'(order_err), 64'd0);
    chk("mid_after_order", out_order, 64'd100);
    chk("mid_after_count", 64'(count), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uvma_rvfi_retire_serializer.md
Name: uvma_rvfi_retire_serializer

Overview:
- Parametrised multi-retire RVFI front end for the instruction monitor path.
- Accepts up to NRET retirements per clock on parallel RVFI lanes and buffers them in a circular FIFO.
- Emits them one per cycle, in lane order, on a ready/valid stream toward the single-retire monitor and scoreboard.
- Checks that retirement order numbers are contiguous, and flags overflow and order errors as sticky status.

Parameters:
- NRET, 2, number of retirement lanes per cycle (>=1).
- DEPTH, 8, FIFO entries; power of two, >= NRET.
- ILEN, 32, instruction width.
- XLEN, 32, data/PC width.
- ORDER_WL, 64, width of the rvfi_order field.
- GPR_ADDR_WL, 5, register address width.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous reset, active-high.
- rvfi_valid  in  NRET  per-lane retire valid.
- rvfi_order  in  NRET*ORDER_WL  per-lane order; lane i occupies bits [i*ORDER_WL +: ORDER_WL].
- rvfi_insn  in  NRET*ILEN  per-lane instruction word.
- rvfi_trap  in  NRET  per-lane trap flag.
- rvfi_pc_rdata  in  NRET*XLEN  per-lane PC.
- rvfi_rd1_addr  in  NRET*GPR_ADDR_WL  per-lane rd address.
- rvfi_rd1_wdata  in  NRET*XLEN  per-lane rd write data.
- out_valid  out  1  head entry available.
- out_ready  in  1  consumer accepts head.
- out_order  out  ORDER_WL  head order.
- out_insn  out  ILEN  head instruction.
- out_trap  out  1  head trap flag.
- out_pc_rdata  out  XLEN  head PC.
- out_rd1_addr  out  GPR_ADDR_WL  head rd address.
- out_rd1_wdata  out  XLEN  head rd write data.
- count  out  $clog2(DEPTH+1)  current occupancy.
- overflow  out  1  sticky: a retire group was dropped.
- order_err  out  1  sticky: order discontinuity was detected.

Behaviour:
- Reset (async assert, sync release): rd/wr pointers 0, count 0, out_valid 0, all out_* data 0, overflow 0, order_err 0, expect_vld 0.
- Push, per cycle: n = popcount(rvfi_valid).
  - Valid lanes are compacted: lowest lane index is written first at wr_ptr, next at wr_ptr+1, and so on. Sparse lane patterns are legal.
- Pop: occurs when out_valid && out_ready; rd_ptr advances by 1.
- Capacity rule: free = DEPTH - count + pop, so a same-cycle pop frees a slot.
  - If n > free, the whole group is dropped (no partial write), overflow is set to 1, and pointers and count are unaffected by the push.
- Pointers wrap modulo DEPTH. count_next = count + (accepted ? n : 0) - pop.
- Latency: an entry pushed in cycle N is visible at the outputs in cycle N+1 at the earliest.
- out_valid = (count != 0). The out_* fields are driven from the entry at rd_ptr. They hold stable while out_valid && !out_ready.
- Out fields are unspecified when out_valid=0; the implementation holds the last value.
- Order check, applied only to accepted groups and walked in compacted order:
  - If expect_vld=0, the first entry loads expect = order+1 and sets expect_vld=1.
  - Otherwise, an entry whose order != expect sets order_err=1.
  - In both cases expect resyncs to that entry's order+1, so a single gap flags once.
  - Dropped groups do not update expect. The next accepted group is therefore checked against pre-drop expectation, and a mismatch is flagged.
- Order arithmetic is modulo 2^ORDER_WL; wrap from all-ones to 0 is contiguous.
- overflow and order_err clear only on reset.
- Reset mid-operation: all state clears immediately on assertion; in-flight entries are lost. Pushes during reset are ignored.

Test Plan:
- NRET=2, out_ready=1, cycle 0: both lanes valid, orders 1,2 -> out_valid rises cycle 1 with out_order=1; cycle 2 out_order=2; cycle 3 out_valid=0; order_err=0.
- Sparse: only lane 1 valid, order 5, insn 0x00000013 -> cycle+1: out_order=5, out_insn=0x00000013, count=1.
- Fill/overflow: out_ready=0, DEPTH=8, four cycles of two valid lanes (orders 1..8) -> count=8. Fifth group (9,10) -> overflow=1, count=8. Then out_ready=1 drains orders 1..8 in sequence. Next group 11,12 -> order_err=1 (expected 9).
- Gap: accepted orders 1,2 then 4 -> order_err=1 the cycle after 4 is pushed. Subsequent order 5 adds no new violation; order_err stays 1.
- Push/pop at full: count=8, out_ready=1, one lane valid -> group accepted, overflow=0, count stays 8, head advances.
- Reset mid-run: count=5, overflow=1, assert reset asynchronously -> out_valid=0, count=0, overflow=0 immediately. After release, order 100 is accepted without order_err.
